wave_capture: RTL
=================

Name: wave_capture

Overview:
- Capture-side counterpart of the lab DAC waveform generators.
- Samples an 8-bit ADC/DAC-loopback bus on an external, slow sample strobe.
- Tracks the signal's level with a hysteresis comparator and reports, per waveform period, the period length in samples plus the min and max sample values.
- Results leave through a valid/ready output register for a display or UART block downstream.

Parameters:
DW, 8, sample data width
PERIOD_W, 16, width of period counter / meas_period
MID, 128, comparator midpoint (unsigned, DW bits)
HYST, 16, hysteresis half-width; high threshold MID+HYST, low threshold MID-HYST

Ports:
sys_clk  input  1  system clock (50 MHz)
sys_rst  input  1  reset, asynchronous, active-high
adc_clk  input  1  sample strobe, asynchronous to sys_clk, ≤ sys_clk/8
adc_data  input  DW  sample value, stable ≥4 sys_clk cycles either side of adc_clk rise
meas_ready  input  1  downstream accepts result
meas_valid  output  1  result available
meas_period  output  PERIOD_W  samples in last full period
meas_min  output  DW  minimum sample in that period
meas_max  output  DW  maximum sample in that period
meas_sat  output  1  meas_period saturated for this result
overrun  output  1  sticky: a result was dropped

Behaviour:
- Reset (async, sys_rst=1): all outputs 0; level=LOW; state=ARM; sync flops, period counter, min and max accumulators all 0.
- Strobe path: adc_clk goes through a 2-flop synchroniser, then a rising-edge detect register.
- sample_stb pulses for 1 cycle on the 3rd sys_clk edge after adc_clk rises. adc_data is registered on that cycle.
- Level comparator, updated on each accepted sample:
  - LOW→HIGH when sample ≥ MID+HYST.
  - HIGH→LOW when sample ≤ MID-HYST.
  - Otherwise hold.
- A sample that causes LOW→HIGH is a boundary sample.
- States: ARM, RUN.
  - ARM: the first boundary sample moves to RUN and produces no result.
  - RUN: every boundary sample ends the current window and starts a new one.
- Window accumulators:
  - On a boundary sample: cnt=1, min=max=sample.
  - On a non-boundary sample in RUN: cnt+=1, saturating at all-ones (sets a sat bit); min=min(min,sample); max=max(max,sample).
  - Comparisons are unsigned.
- Result on a boundary sample in RUN, before the accumulators are re-initialised:
  - If meas_valid=0, or meas_valid=1 with meas_ready=1 this cycle: load meas_period=cnt, meas_min, meas_max, meas_sat=sat. meas_valid=1 on the next cycle.
  - Otherwise the result is dropped, outputs are unchanged, and overrun is set to 1 until reset.
  - Accumulators re-initialise in both cases.
- Handshake:
  - Transfer occurs when meas_valid & meas_ready on a sys_clk edge. meas_valid then clears unless a new result loads the same cycle, in which case it stays 1 with the new data.
  - Outputs hold stable while meas_valid=1 and meas_ready=0.
- Latency: meas_valid rises 4 sys_clk cycles after the adc_clk rise of the boundary sample.
- Signals that never cross both thresholds produce no boundary and no result; the block stays in ARM or RUN with the counter saturating.
- Reset mid-window discards all partial state. The next result requires a fresh arming boundary.
- adc_clk high at reset release produces no sample until it falls and rises again; the edge detect register resets to 0 and the sync flops reset to 0, then see 1.

Test Plan:
- Sawtooth 0..255 wrapping, 1 sample/strobe, meas_ready=1 → first result after second crossing of 144: meas_period=256, meas_min=0, meas_max=255, meas_sat=0. Repeats every 256 samples.
- Triangle 0→255→1 repeating (510 samples/period) → meas_period=510, min=0, max=255.
- Constant 128 for 1000 samples, then constant 200 → no meas_valid during the 128 phase. The 200 step arms only; still no result.
- Sawtooth with meas_ready=0 across 3 boundaries → first result (256/0/255) held stable, overrun=1. Raise meas_ready → single transfer, meas_valid drops, next boundary delivers a new result.
- PERIOD_W=8, sawtooth 0..255 → meas_period=255, meas_sat=1.
- Assert sys_rst for 2 cycles mid-window, asynchronously to sys_clk → outputs 0 immediately. After release, the first boundary produces no result; the next full period reports 256/0/255.

Source files
------------

// File: rtl/wave_capture_if.sv
// Result channel of wave_capture: one period measurement per transfer,
// plus a sticky overrun flag for results dropped while the channel was full.
interface wave_capture_if #(
   parameter int DW       = 8,
   parameter int PERIOD_W = 16
);
   logic                meas_ready;
   logic                meas_valid;
   logic [PERIOD_W-1:0] meas_period;
   logic [DW-1:0]       meas_min;
   logic [DW-1:0]       meas_max;
   logic                meas_sat;
   logic                overrun;

   modport master (
      input  meas_ready,
      output meas_valid, meas_period, meas_min, meas_max, meas_sat, overrun
   );

   modport slave (
      output meas_ready,
      input  meas_valid, meas_period, meas_min, meas_max, meas_sat, overrun
   );
endinterface

// File: rtl/wave_capture.sv
// Samples a slow ADC strobe, tracks level with hysteresis and reports period
// length (in samples) plus min/max per waveform period over a valid/ready register.
module wave_capture #(
   parameter int DW       = 8,
   parameter int PERIOD_W = 16,
   parameter int MID      = 128,
   parameter int HYST     = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          adc_clk,
   input  logic [DW-1:0] adc_data,
   wave_capture_if.master meas
);
   localparam logic [DW:0] TH_HI = (DW+1)'(MID + HYST);
   localparam logic [DW:0] TH_LO = (DW+1)'(MID - HYST);

   typedef enum logic {ARM, RUN} state_t;

   state_t              state_q, state_d;
   logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [1:0]          warm_q, warm_d;
   logic                low_seen_q, low_seen_d;
   logic                stb_q, stb_d;
   logic [DW-1:0]       data_q, data_d;
   logic                level_q, level_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                sat_q, sat_d;
   logic [DW-1:0]       min_q, min_d, max_q, max_d;
   logic                valid_q, valid_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [DW-1:0]       omin_q, omin_d, omax_q, omax_d;
   logic                osat_q, osat_d;
   logic                ovr_q, ovr_d;

   logic                rise;
   logic                boundary;
   logic [DW:0]         samp;

   always_comb begin
      s1_d       = adc_clk;
      s2_d       = s1_q;
      s3_d       = s2_q;
      warm_d     = {warm_q[0], 1'b1};
      // A low level must be seen after the synchroniser has flushed, so a strobe
      // already high at reset release is not mistaken for a fresh rise.
      low_seen_d = low_seen_q | (warm_q[1] & ~s2_q);
      rise       = s2_q & ~s3_q & low_seen_q;
      stb_d      = rise;
      data_d     = rise ? adc_data : data_q;

      samp       = {1'b0, data_q};
      boundary   = stb_q & ~level_q & (samp >= TH_HI);

      state_d    = state_q;
      level_d    = level_q;
      cnt_d      = cnt_q;
      sat_d      = sat_q;
      min_d      = min_q;
      max_d      = max_q;
      valid_d    = valid_q;
      period_d   = period_q;
      omin_d     = omin_q;
      omax_d     = omax_q;
      osat_d     = osat_q;
      ovr_d      = ovr_q;

      if (valid_q && meas.meas_ready) valid_d = 1'b0;

      if (stb_q) begin
         if (!level_q && samp >= TH_HI)     level_d = 1'b1;
         else if (level_q && samp <= TH_LO) level_d = 1'b0;

         if (boundary) begin
            if (state_q == RUN) begin
               if (!valid_q || meas.meas_ready) begin
                  valid_d  = 1'b1;
                  period_d = cnt_q;
                  omin_d   = min_q;
                  omax_d   = max_q;
                  osat_d   = sat_q;
               end else begin
                  ovr_d    = 1'b1;
               end
            end
            state_d = RUN;
            cnt_d   = PERIOD_W'(1);
            sat_d   = 1'b0;
            min_d   = data_q;
            max_d   = data_q;
         end else if (state_q == RUN) begin
            if (cnt_q == '1) sat_d = 1'b1;
            else             cnt_d = cnt_q + PERIOD_W'(1);
            if (data_q < min_q) min_d = data_q;
            if (data_q > max_q) max_d = data_q;
         end
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ARM;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         s3_q       <= 1'b0;
         warm_q     <= '0;
         low_seen_q <= 1'b0;
         stb_q      <= 1'b0;
         data_q     <= '0;
         level_q    <= 1'b0;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         min_q      <= '0;
         max_q      <= '0;
         valid_q    <= 1'b0;
         period_q   <= '0;
         omin_q     <= '0;
         omax_q     <= '0;
         osat_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         warm_q     <= warm_d;
         low_seen_q <= low_seen_d;
         stb_q      <= stb_d;
         data_q     <= data_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         min_q      <= min_d;
         max_q      <= max_d;
         valid_q    <= valid_d;
         period_q   <= period_d;
         omin_q     <= omin_d;
         omax_q     <= omax_d;
         osat_q     <= osat_d;
         ovr_q      <= ovr_d;
      end
   end

   assign meas.meas_valid  = valid_q;
   assign meas.meas_period = period_q;
   assign meas.meas_min    = omin_q;
   assign meas.meas_max    = omax_q;
   assign meas.meas_sat    = osat_q;
   assign meas.overrun     = ovr_q;
endmodule
